dtc_vote_window: RTL and testbench
==================================

# dtc_vote_window

Streaming majority voter that sits directly downstream of a decision-tree classifier node. It consumes one 8-bit classifier output vector per accepted beat and accumulates a per-bit vote count over a window of `WINDOW` samples. At window close, or on an explicit flush, it emits a single voted vector. The voter smooths per-sample classification noise before results are handed to the rest of the pipeline.

## Interface
- `WIDTH`, default 8: classifier output vector width; one vote lane per bit.
- `WINDOW`, default 16: samples per full window; legal range is ≥1.
- `CW`, default `$clog2(WINDOW+1)`: width of the per-lane and sample counters (derived; do not override).

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the upstream classifier vector is valid.
- `in_ready` out 1: the block can accept a sample.
- `in_data` in `WIDTH`: classifier output vector.
- `flush` in 1: close the current partial window early. Single-cycle qualifier.
- `out_valid` out 1: a voted result is available.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out `WIDTH`: voted vector.
- `out_n` out `CW`: number of samples that contributed to `out_data`.

## Operation
- A two-state FSM controls the block.
  - `ACCUM`: `in_ready`=1.
  - `EMIT`: `in_ready`=0, `out_valid`=1.
  - `in_ready` is decoded combinationally from the state.
- **Accept.** A sample is accepted when `in_valid && in_ready`.
  - Sample counter `n` increments by 1.
  - Each lane `i` increments `cnt[i]` when `in_data[i]`=1.
- **Window close.** The window closes on the accepting beat that makes `n == WINDOW`, or in `ACCUM` when `flush`=1 and the post-beat `n` is ≥1.
  - On close, the block registers `out_data[i] = (2*cnt[i] > n)` and `out_n = n`, using post-beat values. This is a strict majority; ties give 0.
  - The state then moves to `EMIT`.
- **Arithmetic.** The comparison `2*cnt > n` is evaluated at `CW+1` bits, so it cannot overflow. Counters never exceed `WINDOW`.
- **Emit.** `out_valid`, `out_data` and `out_n` hold stable until `out_valid && out_ready`.
  - On that cycle all `cnt`, and `n`, clear to 0 and the state returns to `ACCUM`.
  - `out_data` and `out_n` keep their last values; they are don't-care while `out_valid`=0.
- **Boundary cases.**
  - Accept and flush in the same cycle: the sample is included, then the window closes.
  - `flush` with `n`=0 and no accept: ignored.
  - `flush` in `EMIT`: ignored (not queued).
  - `in_valid` in `EMIT`: not accepted; upstream must hold the sample.
  - `WINDOW`=1: every accepted sample closes immediately. `out_data` equals the sample and `out_n`=1.
- **Reset.** `rst` mid-window or mid-emit discards all state with no partial output.
  - Reset values: state=`ACCUM`, `cnt`=0, `n`=0, `out_valid`=0, `out_data`=0, `out_n`=0.
  - `in_ready`=1 from the first cycle after reset deasserts.

## Timing
- `out_valid` rises on the cycle after the closing accept or flush.
- `in_ready` drops in that same cycle.
- `in_ready` returns the cycle after the output handshake. No sample is accepted in the handshake cycle itself.
- Minimum full-window period: `WINDOW`+1 cycles, plus any `out_ready` stall.
- No combinational path from `in_valid`, `flush` or `out_ready` to any output.
- Only internal state feeds `in_ready` and `out_valid`.

## Structure
- Shared package `dtc_vote_pkg`:
  - state enum `{ACCUM, EMIT}`;
  - counter-width helper function.
- Sub-module `dtc_vote_lane`: one `CW`-bit vote counter per lane, with `inc`/`clr` inputs. Instantiated `WIDTH` times by a generate loop.
- The top level holds the FSM, the sample counter `n`, and the output registers.

## Test plan
Bench parameters: `WIDTH`=8, `WINDOW`=4.
- **Full window, output always ready.** Feed 0xFF, 0xFF, 0xFF, 0x00 back-to-back → `out_data`=0xFF, `out_n`=4. `out_valid` appears the cycle after the 4th accept.
- **Tie rule.** Feed 0x0F, 0xF0, 0x0F, 0xF0 → `out_data`=0x00, `out_n`=4.
- **Early flush.** Feed 0x01, 0x01, 0x00, then `flush` alone → `out_data`=0x01, `out_n`=3.
- **Flush at empty, flush with accept.**
  - `flush` at `n`=0 → no `out_valid`.
  - `flush` together with the first sample 0xA5 → `out_data`=0xA5, `out_n`=1.
- **Backpressure.** Close a window, hold `out_ready`=0 for 5 cycles while `in_valid`=1.
  - During the stall: `out_valid` and `out_data` are stable and `in_ready`=0.
  - After `out_ready`: the next window counts exactly 4 new samples.
- **Reset mid-window.** Accept 0xFF twice, pulse `rst`, then feed 0x00 ×4 → `out_data`=0x00, `out_n`=4. No stale votes carry over.

Source files
------------

// File: rtl/dtc_vote_pkg.sv
// Shared definitions for the dtc_vote_window majority voter: FSM state
// encoding and the counter-width helper used to size vote counters.
package dtc_vote_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } vote_state_t;

  // Bits needed to hold any count in 0..window inclusive.
  function automatic int unsigned cnt_width(input int unsigned window);
    int unsigned w;
    w = $clog2(window + 32'd1);
    if (w == 32'd0) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/dtc_vote_lane.sv
// One vote lane: a saturation-free counter of '1' votes for a single bit of
// the classifier vector. Clear wins over increment.
module dtc_vote_lane #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_r;

  // Vote counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/dtc_vote_window.sv
// Windowed per-bit strict-majority voter placed after a decision-tree
// classifier node; emits one voted vector per full window or flush.
module dtc_vote_window
  import dtc_vote_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16,
  parameter int CW     = cnt_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_n
);

  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

  vote_state_t      state_r;
  vote_state_t      state_nxt_s;
  logic [CW-1:0]    n_r;
  logic [CW-1:0]    n_post_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CW-1:0]    out_n_r;

  logic             accept_s;
  logic             close_s;
  logic             handshake_s;
  logic [WIDTH-1:0] vote_s;
  logic [CW-1:0]    cnt_s      [WIDTH];
  logic [CW-1:0]    cnt_post_s [WIDTH];

  assign accept_s    = in_valid && (state_r == ACCUM);
  assign handshake_s = out_valid_r && out_ready;
  assign n_post_s    = n_r + {{(CW-1){1'b0}}, accept_s};

  // A close needs at least one sample in the window, counting this beat's.
  assign close_s = (state_r == ACCUM) &&
                   ((accept_s && (n_post_s == WIN_C)) ||
                    (flush && (n_post_s != {CW{1'b0}})));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      dtc_vote_lane #(
        .CW (CW)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .inc (accept_s && in_data[gi]),
        .clr (handshake_s),
        .cnt (cnt_s[gi])
      );
      assign cnt_post_s[gi] = cnt_s[gi] + {{(CW-1){1'b0}}, (accept_s && in_data[gi])};
    end
  endgenerate

  // Strict majority per lane, compared one bit wider than the counters
  always_comb begin
    vote_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      vote_s[i] = ({cnt_post_s[i], 1'b0} > {1'b0, n_post_s});
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (close_s) begin
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      EMIT: begin
        if (handshake_s) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sample counter: counts accepted beats, cleared by the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r <= {CW{1'b0}};
    end else if (handshake_s) begin
      n_r <= {CW{1'b0}};
    end else if (accept_s) begin
      n_r <= n_post_s;
    end else begin
      n_r <= n_r;
    end
  end

  // Output registers: loaded on close, held through the stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_n_r     <= {CW{1'b0}};
    end else if (close_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= vote_s;
      out_n_r     <= n_post_s;
    end else if (handshake_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_n_r     <= out_n_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_n_r     <= out_n_r;
    end
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_n     = out_n_r;

endmodule

// File: tb/tb_dtc_vote_window.sv
// Self-checking bench for dtc_vote_window (WIDTH=8, WINDOW=4) against a
// queue-based window model that recomputes majorities by counting ones.
module tb_dtc_vote_window;

  localparam int W   = 8;
  localparam int WIN = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_n;

  int checks;
  int failures;

  // Reference model state
  logic         m_emit;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_od;
  logic [2:0]   m_on;

  dtc_vote_window #(
    .WIDTH  (W),
    .WINDOW (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_n     (out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model one cycle and drive the same inputs through one DUT edge.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    int ones;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    if (m_emit) begin
      if (r) begin
        m_emit = 1'b0;
        m_q.delete();
      end
    end else begin
      if (v) m_q.push_back(d);
      if (m_q.size() == WIN || (f && m_q.size() > 0)) begin
        for (int b = 0; b < W; b++) begin
          ones = 0;
          foreach (m_q[k]) ones += int'(m_q[k][b]);
          m_od[b] = (2 * ones > m_q.size());
        end
        m_on   = 3'(m_q.size());
        m_emit = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_emit = 1'b0;
    m_q.delete();
    m_od   = 8'h00;
    m_on   = 3'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    if (out_n !== 3'd0) begin failures++; $display("FAIL reset_out_n got=%0d exp=0", out_n); end
  endtask

  // Feeds four samples with out_ready high and checks the emitted vote.
  task automatic run_window(input string nm, input logic [31:0] s, input logic [W-1:0] exp_d);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, s[31-8*i -: 8], 1'b0, 1'b1);
      checks++;
      if (out_valid !== (i == 3)) begin
        failures++;
        $display("FAIL %s_valid_beat%0d got=%b exp=%b", nm, i, out_valid, (i == 3));
      end
    end
    checks += 3;
    if (out_data !== exp_d) begin failures++; $display("FAIL %s_data got=%h exp=%h", nm, out_data, exp_d); end
    if (out_n !== 3'd4) begin failures++; $display("FAIL %s_n got=%0d exp=4", nm, out_n); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_in_ready got=%b exp=0", nm, in_ready); end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_drain_valid got=%b exp=0", nm, out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_drain_ready got=%b exp=1", nm, in_ready); end
  endtask

  task automatic test_full_window();
    run_window("full", 32'hFFFF_FF00, 8'hFF);
  endtask

  task automatic test_tie();
    run_window("tie", 32'h0FF0_0FF0, 8'h00);
  endtask

  task automatic test_early_flush();
    tick(1'b1, 8'h01, 1'b0, 1'b1);
    tick(1'b1, 8'h01, 1'b0, 1'b1);
    tick(1'b1, 8'h00, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_pre_valid got=%b exp=0", out_valid); end
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%b exp=1", out_valid); end
    if (out_data !== 8'h01) begin failures++; $display("FAIL flush_data got=%h exp=01", out_data); end
    if (out_n !== 3'd3) begin failures++; $display("FAIL flush_n got=%0d exp=3", out_n); end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_flush_edges();
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_valid got=%b exp=0", out_valid); end
    tick(1'b1, 8'hA5, 1'b1, 1'b1);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_acc_valid got=%b exp=1", out_valid); end
    if (out_data !== 8'hA5) begin failures++; $display("FAIL flush_acc_data got=%h exp=a5", out_data); end
    if (out_n !== 3'd1) begin failures++; $display("FAIL flush_acc_n got=%0d exp=1", out_n); end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    held = out_data;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_close_valid got=%b exp=1", out_valid); end
    if (out_data !== m_od) begin failures++; $display("FAIL bp_close_data got=%h exp=%h", out_data, m_od); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_valid c%0d got=%b exp=1", i, out_valid); end
      if (out_data !== held) begin failures++; $display("FAIL bp_stall_data c%0d got=%h exp=%h", i, out_data, held); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready c%0d got=%b exp=0", i, in_ready); end
    end
    tick(1'b1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 8'($urandom), 1'b0, 1'b0);
      checks++;
      if (out_valid !== (i == 3)) begin failures++; $display("FAIL bp_next_valid beat%0d got=%b exp=%b", i, out_valid, (i == 3)); end
    end
    checks += 2;
    if (out_n !== 3'd4) begin failures++; $display("FAIL bp_next_n got=%0d exp=4", out_n); end
    if (out_data !== m_od) begin failures++; $display("FAIL bp_next_data got=%h exp=%h", out_data, m_od); end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_window();
    tick(1'b1, 8'hFF, 1'b0, 1'b1);
    tick(1'b1, 8'hFF, 1'b0, 1'b1);
    do_reset();
    run_window("rst_mid", 32'h0000_0000, 8'h00);
  endtask

  task automatic test_random();
    logic v, f, r;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 3) != 0);
      tick(v, 8'($urandom), f, r);
      checks += 2;
      if (out_valid !== m_emit) begin failures++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, out_valid, m_emit); end
      if (in_ready !== !m_emit) begin failures++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, in_ready, !m_emit); end
      if (m_emit) begin
        checks += 2;
        if (out_data !== m_od) begin failures++; $display("FAIL rnd_data c%0d got=%h exp=%h", c, out_data, m_od); end
        if (out_n !== m_on) begin failures++; $display("FAIL rnd_n c%0d got=%0d exp=%0d", c, out_n, m_on); end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_emit   = 1'b0;
    m_od     = 8'h00;
    m_on     = 3'd0;
    test_reset();
    test_full_window();
    test_tie();
    test_early_flush();
    test_flush_edges();
    test_backpressure();
    test_reset_mid_window();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
